// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: a Moore FSM that sequences one shared ALU and one
// memory port through fetch, decode, execute, memory and writeback steps.
module multicycle_controller #(
  parameter int ALUC_W      = 3,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              iord,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_src,
  output logic [ALUC_W-1:0] alucontrol,
  output logic              pc_en,
  output logic              instr_done,
  output logic              illegal,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BREX    = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] alu_op;
  logic [2:0] rtype_op;
  logic       funct_ok;
  logic       is_mem;
  logic       is_rtype;
  logic       is_branch;
  logic       is_addi;
  logic       is_j;

  // R-type funct field to ALU operation; unknown functs are rejected at DECODE.
  always_comb begin
    rtype_op = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: rtype_op = ALU_ADD;
      6'b100010: rtype_op = ALU_SUB;
      6'b100100: rtype_op = ALU_AND;
      6'b100101: rtype_op = ALU_OR;
      6'b101010: rtype_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  assign is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_rtype  = (opcode == OP_RTYPE) && funct_ok;
  assign is_branch = (opcode == OP_BEQ) || (SUPPORT_BNE && (opcode == OP_BNE));
  assign is_addi   = (opcode == OP_ADDI);
  assign is_j      = (opcode == OP_J);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so that no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = ALU_ADD;
    pc_en      = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if      (is_mem)    state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_RTYPEEX;
        else if (is_branch) state_d = S_BREX;
        else if (is_addi)   state_d = S_ADDIEX;
        else if (is_j)      state_d = S_JEX;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        // The write strobe is held through the stall; completion marks the last cycle.
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = rtype_op;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BREX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b00;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JEX: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // While reset is held the datapath sees FETCH selects with every enable off.
    if (reset) begin
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      pc_src     = 2'b00;
      alu_op     = ALU_ADD;
      pc_en      = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign alucontrol = ALUC_W'(alu_op);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into its
// expected per-cycle output trace from the instruction-level timing rules.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en, instr_done, illegal;
    logic [3:0] aluc;
  } cyc_t;

  typedef enum int {K_LW, K_SW, K_R, K_RBAD, K_BEQ, K_BNE, K_ADDI, K_J, K_BAD} kind_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alucontrol;
  logic       pc_en, instr_done, illegal;
  logic [3:0] state;

  logic [5:0] opcode2, funct2;
  logic       zero2, mem_ready2;
  logic       iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [2:0] alucontrol2;
  logic       pc_en2, instr_done2, illegal2;
  logic [3:0] state2;

  int n_checks = 0;
  int n_fail   = 0;
  int instr_no = 0;

  cyc_t exp_q[$];
  bit   mr_q[$];
  bit   rs_q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.ALUC_W(4), .SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alucontrol(alucontrol), .pc_en(pc_en), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  multicycle_controller #(.ALUC_W(3), .SUPPORT_BNE(1'b0)) dut_nobne (
    .clk(clk), .reset(reset), .opcode(opcode2), .funct(funct2), .zero(zero2),
    .mem_ready(mem_ready2), .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
    .alucontrol(alucontrol2), .pc_en(pc_en2), .instr_done(instr_done2),
    .illegal(illegal2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t blank(input logic [3:0] st);
    cyc_t c;
    c      = '0;
    c.st   = st;
    c.aluc = 4'b0010;
    return c;
  endfunction

  function automatic logic [3:0] alu_for_funct(input logic [5:0] f);
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [5:0] op_for(input kind_t k);
    logic [5:0] bad_ops [5];
    bad_ops = '{6'h3f, 6'h0d, 6'h20, 6'h01, 6'h03};
    case (k)
      K_LW:   return 6'b100011;
      K_SW:   return 6'b101011;
      K_BEQ:  return 6'b000100;
      K_BNE:  return 6'b000101;
      K_ADDI: return 6'b001000;
      K_J:    return 6'b000010;
      K_BAD:  return bad_ops[$urandom_range(0, 4)];
      default: return 6'b000000;
    endcase
  endfunction

  function automatic cyc_t observed();
    cyc_t c;
    c = '{state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
          alu_src_b, pc_src, pc_en, instr_done, illegal, alucontrol};
    return c;
  endfunction

  task automatic push(input cyc_t c, input bit mr, input bit rs);
    exp_q.push_back(c);
    mr_q.push_back(mr);
    rs_q.push_back(rs);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic run_q();
    for (int i = 0; i < exp_q.size(); i++) begin
      reset     = rs_q[i];
      mem_ready = mr_q[i];
      @(negedge clk);
      check($sformatf("instr%0d cyc%0d st%0d", instr_no, i, exp_q[i].st),
            32'(observed()), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    mr_q.delete();
    rs_q.delete();
    instr_no++;
  endtask

  task automatic build_fetch(input int fs);
    cyc_t c;
    c = blank(4'd0);
    c.alu_src_b = 2'b01;
    for (int i = 0; i < fs; i++) push(c, 1'b0, 1'b0);
    c.ir_write = 1'b1;
    c.pc_en    = 1'b1;
    push(c, 1'b1, 1'b0);
  endtask

  task automatic build_decode(input bit bad);
    cyc_t c;
    c = blank(4'd1);
    c.alu_src_b = 2'b11;
    c.illegal   = bad;
    push(c, 1'($urandom), 1'b0);
  endtask

  task automatic build_memadr();
    cyc_t c;
    c = blank(4'd2);
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'b10;
    push(c, 1'($urandom), 1'b0);
  endtask

  task automatic build_body(input kind_t k, input logic [5:0] f, input logic z, input int ms);
    cyc_t c;
    case (k)
      K_LW: begin
        build_memadr();
        c = blank(4'd3);
        c.iord = 1'b1;
        for (int i = 0; i < ms; i++) push(c, 1'b0, 1'b0);
        push(c, 1'b1, 1'b0);
        c = blank(4'd4);
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        push(c, 1'($urandom), 1'b0);
      end
      K_SW: begin
        build_memadr();
        c = blank(4'd5);
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        for (int i = 0; i < ms; i++) push(c, 1'b0, 1'b0);
        c.instr_done = 1'b1;
        push(c, 1'b1, 1'b0);
      end
      K_R: begin
        c = blank(4'd6);
        c.alu_src_a = 1'b1;
        c.aluc      = alu_for_funct(f);
        push(c, 1'($urandom), 1'b0);
        c = blank(4'd7);
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        push(c, 1'($urandom), 1'b0);
      end
      K_BEQ, K_BNE: begin
        c = blank(4'd8);
        c.alu_src_a  = 1'b1;
        c.aluc       = 4'b0110;
        c.pc_src     = 2'b01;
        c.pc_en      = (k == K_BEQ) ? z : ~z;
        c.instr_done = 1'b1;
        push(c, 1'($urandom), 1'b0);
      end
      K_ADDI: begin
        build_memadr_like_addi();
        c = blank(4'd10);
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        push(c, 1'($urandom), 1'b0);
      end
      K_J: begin
        c = blank(4'd11);
        c.pc_src     = 2'b10;
        c.pc_en      = 1'b1;
        c.instr_done = 1'b1;
        push(c, 1'($urandom), 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic build_memadr_like_addi();
    cyc_t c;
    c = blank(4'd9);
    c.alu_src_a = 1'b1;
    c.alu_src_b = 2'b10;
    push(c, 1'($urandom), 1'b0);
  endtask

  task automatic exec_instr(input kind_t k, input logic [5:0] f, input logic z,
                            input int fs, input int ms);
    opcode = op_for(k);
    funct  = f;
    zero   = z;
    build_fetch(fs);
    build_decode(k == K_BAD || k == K_RBAD);
    build_body(k, f, z, ms);
    run_q();
  endtask

  // Aborts a lw (MEMRD) or sw (MEMWR) mid-stall with a one-cycle reset.
  task automatic reset_mid(input bit is_sw);
    cyc_t c;
    opcode = is_sw ? 6'b101011 : 6'b100011;
    funct  = 6'($urandom);
    zero   = 1'b0;
    build_fetch(0);
    build_decode(1'b0);
    build_memadr();
    c = blank(is_sw ? 4'd5 : 4'd3);
    c.iord      = 1'b1;
    c.mem_write = is_sw;
    push(c, 1'b0, 1'b0);
    push(c, 1'b0, 1'b0);
    c = blank(is_sw ? 4'd5 : 4'd3);
    c.alu_src_b = 2'b01;
    push(c, 1'b0, 1'b1);
    run_q();
  endtask

  initial begin
    logic [5:0] legal_fn [5];
    logic [5:0] bad_fn   [4];
    kind_t      k;
    logic [5:0] f;
    cyc_t       c;

    legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bad_fn   = '{6'b000111, 6'b000000, 6'b111111, 6'b100001};

    reset      = 1'b1;
    opcode     = 6'b100011;
    funct      = 6'b0;
    zero       = 1'b0;
    mem_ready  = 1'b1;
    opcode2    = 6'b000101;
    funct2     = 6'b0;
    zero2      = 1'b0;
    mem_ready2 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    c = blank(4'd0);
    c.alu_src_b = 2'b01;
    check("reset_state", 32'(observed()), 32'(c));
    @(posedge clk);
    #1;
    reset = 1'b0;

    exec_instr(K_LW,   6'b0,      1'b0, 0, 0);
    exec_instr(K_SW,   6'b0,      1'b0, 0, 3);
    exec_instr(K_R,    6'b100010, 1'b0, 0, 0);
    exec_instr(K_RBAD, 6'b000111, 1'b0, 0, 0);
    exec_instr(K_BEQ,  6'b0,      1'b1, 0, 0);
    exec_instr(K_BEQ,  6'b0,      1'b0, 0, 0);
    exec_instr(K_BNE,  6'b0,      1'b1, 0, 0);
    exec_instr(K_BNE,  6'b0,      1'b0, 0, 0);
    exec_instr(K_R,    6'b101010, 1'b0, 1, 0);
    exec_instr(K_ADDI, 6'b0,      1'b0, 0, 0);
    exec_instr(K_J,    6'b0,      1'b0, 0, 0);
    exec_instr(K_BAD,  6'b0,      1'b0, 0, 0);

    reset_mid(1'b0);
    exec_instr(K_LW, 6'b0, 1'b0, 2, 0);
    reset_mid(1'b1);
    exec_instr(K_SW, 6'b0, 1'b0, 2, 1);

    for (int n = 0; n < 300; n++) begin
      k = kind_t'($urandom_range(0, 8));
      if (k == K_R)         f = legal_fn[$urandom_range(0, 4)];
      else if (k == K_RBAD) f = bad_fn[$urandom_range(0, 3)];
      else                  f = 6'($urandom);
      exec_instr(k, f, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                 $urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) reset_mid(1'($urandom));
    end

    // Variant without bne support and with a 3-bit alucontrol.
    reset = 1'b1;
    opcode2 = 6'b000101;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("nobne_fetch", {state2, illegal2, ir_write2, alucontrol2}, {4'd0, 1'b0, 1'b1, 3'b010});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("nobne_decode", {state2, illegal2, ir_write2, alucontrol2}, {4'd1, 1'b1, 1'b0, 3'b010});
    @(posedge clk);
    #1;
    opcode2 = 6'b000000;
    funct2  = 6'b100010;
    @(negedge clk);
    check("nobne_refetch", {state2, illegal2, ir_write2, alucontrol2}, {4'd0, 1'b0, 1'b1, 3'b010});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w3_decode", {state2, illegal2, ir_write2, alucontrol2}, {4'd1, 1'b0, 1'b0, 3'b010});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w3_sub", {state2, illegal2, ir_write2, alucontrol2}, {4'd6, 1'b0, 1'b0, 3'b110});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle control unit for the MIPS datapath, the sequential successor to the single-cycle controller. It decodes opcode/funct from the instruction register and walks a Moore FSM (fetch, decode, execute, memory, writeback), so one shared ALU and one memory port serve every instruction. It generalises ALU-control width, optionally supports `bne`, waits on a memory-ready handshake, and reports instruction completion and illegal opcodes.

## Interface
- `ALUC_W`, 3: width of `alucontrol`; codes below are zero-extended; must be ≥3.
- `SUPPORT_BNE`, 1: 1 = opcode 000101 executes as `bne`; 0 = decodes as illegal.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: instr[31:26], held stable by the IR after FETCH.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `iord`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write`, `alu_src_a` out 1: datapath selects and enables.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out `ALUC_W`: ALU operation.
- `pc_en` out 1: PC load enable.
- `instr_done` out 1: one-cycle pulse in the last cycle of each legal instruction.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode/funct.
- `state` out 4: current state, for debug.

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BREX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 go to FETCH next cycle with all enables 0.
- Outputs not listed for a state are 0. `alucontrol` defaults to add (010).
- FETCH: `alu_src_b`=01, add. `ir_write` = `pc_en` = `mem_ready`. Go to DECODE when `mem_ready`=1, else hold.
- DECODE: `alu_src_b`=11, add. Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 with legal funct → RTYPEEX
  - 000100, or 000101 when `SUPPORT_BNE`=1 → BREX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH, with `illegal`=1.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: `iord`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Go to FETCH.
- MEMWR: `iord`=1, `mem_write`=1, held every cycle until `mem_ready`. On that cycle `instr_done`=1 and go to FETCH.
- RTYPEEX: `alu_src_a`=1, `alu_src_b`=00. Funct→alucontrol: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct is illegal at DECODE. Go to RTYPEWB.
- RTYPEWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. Go to FETCH.
- BREX: `alu_src_a`=1, `alu_src_b`=00, sub (110), `pc_src`=01. `pc_en` = `zero` for beq, ~`zero` for bne. `instr_done`=1. Go to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add. Go to ADDIWB.
- ADDIWB: `reg_write`=1, `instr_done`=1. Go to FETCH.
- JEX: `pc_src`=10, `pc_en`=1, `instr_done`=1. Go to FETCH.

## Timing
- Outputs are combinational from `state` (and `zero`/`mem_ready`/`opcode` where stated); `state` is registered.
- Cycles per instruction with `mem_ready` always high:
  - lw 5
  - sw 4, R-type 4, addi 4
  - beq/bne 3, j 3
  - illegal 2
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No enable pulses twice during a stall.
- Reset: `state`=FETCH on the first edge with `reset`=1. While `reset` is high, `mem_write`, `ir_write`, `reg_write`, `pc_en`, `instr_done` and `illegal` are forced 0. Other outputs show FETCH values: `alu_src_b`=01, `alucontrol`=010, everything else 0.
- Reset mid-instruction (including mid-MEMWR stall) aborts; the next cycle is FETCH with no writeback.
- `mem_ready` has no effect outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset then lw, `mem_ready`=1: states 0→1→2→3→4→0. `reg_write`=1 and `mem_to_reg`=1 only in state 4; `instr_done` pulses once.
- sw with `mem_ready` low 3 cycles in MEMWR: `mem_write`=1 for 4 consecutive cycles, `instr_done` only on the 4th, total 7 cycles.
- R-type sub (funct 100010): `alucontrol`=110 in RTYPEEX; `reg_dst`=1, `reg_write`=1 in RTYPEWB. Funct 000111 instead gives `illegal`=1 in DECODE and a return to FETCH.
- beq and bne with `zero`=1 then 0: `pc_en` is 1,0 for beq and 0,1 for bne. With `SUPPORT_BNE`=0, bne flags `illegal`.
- `ALUC_W`=4, slt: `alucontrol`=0111.
- `reset` asserted in MEMRD with `mem_ready`=0: next `state`=0 with no `reg_write`; a FETCH stall of 2 cycles holds `ir_write` at 0 until `mem_ready`.
